// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge ROM fetch path.
// Sits between the cartridge mappers and the SDRAM request port.
package cart_pkg;

   localparam int DEFAULT_ADDR_W = 25;

   localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DONE
   } fetch_state_t;

   // SDRAM words are little-endian: the even byte is in the low half.
   function automatic logic [7:0] selectByte(input logic [15:0] word, input logic sel);
      return sel ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/cart_line_cache.sv
// One 16-bit line per cartridge slot, with a tag and a valid bit per line.
// Lookup is combinational. Fill and flush take effect at the clock edge.
module cart_line_cache
   import cart_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int NSLOT  = 2,
   parameter int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [SLOT_W-1:0] i_lookupSlot,
   input  logic [ADDR_W-2:0] i_lookupTag,
   output logic              o_hit,
   output logic [15:0]       o_line,
   input  logic              i_fillEn,
   input  logic [SLOT_W-1:0] i_fillSlot,
   input  logic [ADDR_W-2:0] i_fillTag,
   input  logic [15:0]       i_fillData,
   input  logic              i_flush
);

   logic [NSLOT-1:0]  r_valid;
   logic [ADDR_W-2:0] r_tag  [NSLOT];
   logic [15:0]       r_line [NSLOT];

   assign o_hit  = r_valid[i_lookupSlot] && (r_tag[i_lookupSlot] == i_lookupTag);
   assign o_line = r_line[i_lookupSlot];

   // A flush that coincides with a fill still stores the data, but the line stays invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
      end else if (i_fillEn) begin
         r_valid[i_fillSlot] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_fillEn) begin
         r_tag[i_fillSlot]  <= i_fillTag;
         r_line[i_fillSlot] <= i_fillData;
      end
   end

endmodule

// File: rtl/cart_rom_fetch.sv
// Relocates mapper offsets into the per-slot SDRAM cartridge region and
// serves CPU reads from a one-word line cache, stalling the CPU on misses.
module cart_rom_fetch
   import cart_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int NSLOT  = 2,
   parameter int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cs,
   input  logic                    rd,
   input  logic [SLOT_W-1:0]       slot,
   input  logic [ADDR_W-1:0]       mem_addr,
   input  logic                    mem_unmaped,
   input  logic [NSLOT*ADDR_W-1:0] rom_base,
   input  logic                    flush,
   output logic                    sdram_req,
   output logic [ADDR_W-1:0]       sdram_addr,
   input  logic                    sdram_ack,
   input  logic [15:0]             sdram_q,
   output logic [7:0]              d_to_cpu,
   output logic                    cpu_wait
);

   fetch_state_t      r_state;
   fetch_state_t      w_nextState;
   logic              r_rdQ;
   logic              r_sdramReq;
   logic              w_nextReq;
   logic [ADDR_W-1:0] r_sdramAddr;
   logic [ADDR_W-1:0] w_nextAddr;
   logic [7:0]        r_dToCpu;
   logic [7:0]        w_nextData;
   logic [SLOT_W-1:0] r_slot;
   logic [SLOT_W-1:0] w_nextSlot;
   logic [ADDR_W-2:0] r_tag;
   logic [ADDR_W-2:0] w_nextTag;
   logic              r_sel;
   logic              w_nextSel;

   logic [ADDR_W-1:0] w_phys;
   logic              w_start;
   logic              w_hit;
   logic [15:0]       w_line;
   logic              w_fillEn;
   logic              w_wait;

   assign w_phys  = rom_base[slot*ADDR_W +: ADDR_W] + mem_addr;
   assign w_start = cs && rd && !r_rdQ;

   cart_line_cache #(
      .ADDR_W (ADDR_W),
      .NSLOT  (NSLOT),
      .SLOT_W (SLOT_W)
   ) u_cache (
      .clk          (clk),
      .reset        (reset),
      .i_lookupSlot (slot),
      .i_lookupTag  (w_phys[ADDR_W-1:1]),
      .o_hit        (w_hit),
      .o_line       (w_line),
      .i_fillEn     (w_fillEn),
      .i_fillSlot   (r_slot),
      .i_fillTag    (r_tag),
      .i_fillData   (sdram_q),
      .i_flush      (flush)
   );

   // Strobe edge detect plus all registered outputs and the latched miss context.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rdQ       <= 1'b0;
         r_sdramReq  <= 1'b0;
         r_sdramAddr <= '0;
         r_dToCpu    <= UNMAPPED_DATA;
         r_slot      <= '0;
         r_tag       <= '0;
         r_sel       <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_rdQ       <= cs && rd;
         r_sdramReq  <= w_nextReq;
         r_sdramAddr <= w_nextAddr;
         r_dToCpu    <= w_nextData;
         r_slot      <= w_nextSlot;
         r_tag       <= w_nextTag;
         r_sel       <= w_nextSel;
      end
   end

   // Strobes outside IDLE cannot happen while the CPU is stalled, so they are dropped
   // and never raise the stall themselves.
   always_comb begin
      w_nextState = r_state;
      w_nextReq   = r_sdramReq;
      w_nextAddr  = r_sdramAddr;
      w_nextData  = r_dToCpu;
      w_nextSlot  = r_slot;
      w_nextTag   = r_tag;
      w_nextSel   = r_sel;
      w_fillEn    = 1'b0;
      w_wait      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               if (mem_unmaped) begin
                  w_nextData = UNMAPPED_DATA;
               end else if (w_hit) begin
                  w_nextData = selectByte(w_line, w_phys[0]);
               end else begin
                  w_wait      = 1'b1;
                  w_nextSlot  = slot;
                  w_nextTag   = w_phys[ADDR_W-1:1];
                  w_nextSel   = w_phys[0];
                  w_nextReq   = 1'b1;
                  w_nextAddr  = {w_phys[ADDR_W-1:1], 1'b0};
                  w_nextState = FETCH;
               end
            end
         end
         FETCH: begin
            w_wait = 1'b1;
            if (sdram_ack) begin
               w_nextReq   = 1'b0;
               w_fillEn    = 1'b1;
               w_nextData  = selectByte(sdram_q, r_sel);
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign sdram_req  = r_sdramReq;
   assign sdram_addr = r_sdramAddr;
   assign d_to_cpu   = r_dToCpu;
   assign cpu_wait   = w_wait;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Directed bench for cart_rom_fetch: miss, hit, unmapped, per-slot isolation,
// flush coincident with a fill, and asynchronous reset in the middle of a fetch.
module tb_cart_rom_fetch;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        rd;
   logic        slot;
   logic [24:0] mem_addr;
   logic        mem_unmaped;
   logic [49:0] rom_base;
   logic        flush;
   logic        sdram_req;
   logic [24:0] sdram_addr;
   logic        sdram_ack;
   logic [15:0] sdram_q;
   logic [7:0]  d_to_cpu;
   logic        cpu_wait;

   int checkCount = 0;
   int errorCount = 0;
   int waitCycles;

   cart_rom_fetch #(
      .ADDR_W (25),
      .NSLOT  (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cs          (cs),
      .rd          (rd),
      .slot        (slot),
      .mem_addr    (mem_addr),
      .mem_unmaped (mem_unmaped),
      .rom_base    (rom_base),
      .flush       (flush),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .sdram_q     (sdram_q),
      .d_to_cpu    (d_to_cpu),
      .cpu_wait    (cpu_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Opens a read strobe just after the next rising edge.
   task automatic applyStimulus(input logic s, input logic [24:0] addr, input logic unm);
      @(posedge clk);
      #1;
      slot        = s;
      mem_addr    = addr;
      mem_unmaped = unm;
      cs          = 1'b1;
      rd          = 1'b1;
   endtask

   task automatic endRead();
      cs          = 1'b0;
      rd          = 1'b0;
      mem_unmaped = 1'b0;
   endtask

   // Called in the strobe cycle of an expected miss; acks in the ackCycles-th FETCH
   // cycle and returns in the DONE cycle with the number of stalled cycles seen.
   task automatic serviceMiss(input int ackCycles, input logic [15:0] q, input logic [24:0] expAddr,
                              input logic flushOnAck, input string tag, output int stalled);
      stalled = 0;
      @(negedge clk);
      if (cpu_wait) stalled++;
      for (int i = 1; i <= ackCycles; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            checkOutput({tag, "_req"}, 32'(sdram_req), 32'd1);
            checkOutput({tag, "_addr"}, 32'(sdram_addr), 32'(expAddr));
         end
         if (i == ackCycles) begin
            sdram_ack = 1'b1;
            sdram_q   = q;
            flush     = flushOnAck;
         end
         @(negedge clk);
         if (cpu_wait) stalled++;
      end
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      flush     = 1'b0;
      checkOutput({tag, "_reqDrop"}, 32'(sdram_req), 32'd0);
      checkOutput({tag, "_waitDone"}, 32'(cpu_wait), 32'd0);
   endtask

   // Called in the strobe cycle of an expected hit or unmapped access.
   task automatic expectNoFetch(input logic [7:0] expData, input string tag);
      @(negedge clk);
      checkOutput({tag, "_wait"}, 32'(cpu_wait), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_data"}, 32'(d_to_cpu), 32'(expData));
      checkOutput({tag, "_req"}, 32'(sdram_req), 32'd0);
      checkOutput({tag, "_heldWait"}, 32'(cpu_wait), 32'd0);
      endRead();
   endtask

   initial begin
      reset       = 1'b1;
      cs          = 1'b0;
      rd          = 1'b0;
      slot        = 1'b0;
      mem_addr    = '0;
      mem_unmaped = 1'b0;
      rom_base    = {25'h180000, 25'h100000};
      flush       = 1'b0;
      sdram_ack   = 1'b0;
      sdram_q     = '0;

      #2;
      checkOutput("reset_req", 32'(sdram_req), 32'd0);
      checkOutput("reset_addr", 32'(sdram_addr), 32'd0);
      checkOutput("reset_data", 32'(d_to_cpu), 32'hFF);
      checkOutput("reset_wait", 32'(cpu_wait), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 0x100000 + 0x04001 = 0x104001: word 0x104000, odd byte
      applyStimulus(1'b0, 25'h04001, 1'b0);
      serviceMiss(3, 16'hA55A, 25'h104000, 1'b0, "miss0", waitCycles);
      checkOutput("miss0_waitCycles", 32'(waitCycles), 32'd4);
      checkOutput("miss0_data", 32'(d_to_cpu), 32'hA5);
      endRead();

      applyStimulus(1'b0, 25'h04000, 1'b0);
      expectNoFetch(8'h5A, "hit0");

      applyStimulus(1'b0, 25'h04001, 1'b1);
      expectNoFetch(8'hFF, "unmapped");

      // Same offset on slot 1 relocates to 0x184001 and must not hit slot 0's line
      applyStimulus(1'b1, 25'h04001, 1'b0);
      serviceMiss(2, 16'h1234, 25'h184000, 1'b0, "slot1", waitCycles);
      checkOutput("slot1_waitCycles", 32'(waitCycles), 32'd3);
      checkOutput("slot1_data", 32'(d_to_cpu), 32'h12);
      endRead();

      applyStimulus(1'b0, 25'h04001, 1'b0);
      expectNoFetch(8'hA5, "slot0Kept");

      applyStimulus(1'b1, 25'h04000, 1'b0);
      expectNoFetch(8'h34, "slot1Hit");

      // 0x100000 + 0x08000 = 0x108000, even byte
      applyStimulus(1'b0, 25'h08000, 1'b0);
      serviceMiss(1, 16'hBEEF, 25'h108000, 1'b1, "flushFill", waitCycles);
      checkOutput("flushFill_data", 32'(d_to_cpu), 32'hEF);
      endRead();

      applyStimulus(1'b0, 25'h08000, 1'b0);
      serviceMiss(1, 16'hCAFE, 25'h108000, 1'b0, "flushRefetch", waitCycles);
      checkOutput("flushRefetch_waitCycles", 32'(waitCycles), 32'd2);
      checkOutput("flushRefetch_data", 32'(d_to_cpu), 32'hFE);
      endRead();

      // 0x100000 + 0x0C000 = 0x10C000; reset lands mid-cycle while in FETCH
      applyStimulus(1'b0, 25'h0C000, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("rstFetch_req", 32'(sdram_req), 32'd1);
      #2;
      reset = 1'b1;
      endRead();
      #1;
      checkOutput("rstAsync_req", 32'(sdram_req), 32'd0);
      checkOutput("rstAsync_data", 32'(d_to_cpu), 32'hFF);
      checkOutput("rstAsync_wait", 32'(cpu_wait), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      @(posedge clk);
      #1;
      sdram_ack = 1'b1;
      sdram_q   = 16'hDEAD;
      @(negedge clk);
      checkOutput("lateAck_wait", 32'(cpu_wait), 32'd0);
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      checkOutput("lateAck_req", 32'(sdram_req), 32'd0);
      checkOutput("lateAck_data", 32'(d_to_cpu), 32'hFF);

      applyStimulus(1'b0, 25'h0C000, 1'b0);
      serviceMiss(1, 16'h7788, 25'h10C000, 1'b0, "postRst", waitCycles);
      checkOutput("postRst_waitCycles", 32'(waitCycles), 32'd2);
      checkOutput("postRst_data", 32'(d_to_cpu), 32'h88);
      endRead();

      // Reset also dropped every valid bit, so the old slot 0 line must be refetched
      applyStimulus(1'b0, 25'h04000, 1'b0);
      serviceMiss(1, 16'h0F0E, 25'h104000, 1'b0, "rstInval", waitCycles);
      checkOutput("rstInval_data", 32'(d_to_cpu), 32'h0E);
      endRead();

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
